midway8080_vram_arbiter: RTL and testbench
==========================================

Name: midway8080_vram_arbiter

Overview:
- Shares the single-port Midway 8080 video RAM (224 columns x 32 bytes = 7168 bytes) between two requesters: the display scanout path and the CPU bus.
- The scanout path feeds the column/byte-address memory adapter.
- The block also generates the animated colour_offset that drives the adapter's rainbow colour bands.
- It sits between the CPU core, the scanout timing logic and the video RAM instance.

Parameters:
- STARVE_LIMIT, 4, consecutive display grants allowed while a CPU request waits; after that the CPU is forced one slot.
- FRAME_DIV, 2, number of frame_tick pulses per colour_offset step.
- OFFSET_STEP, 1, amount added to colour_offset per step.
- OFFSET_WRAP, 196, modulus of colour_offset (7 bands x 28 columns).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disp_req  in  1  scanout requests one byte; held until disp_gnt
- disp_x  in  8  column, 0..223 valid
- disp_ybyte  in  5  byte row, 0..31
- disp_gnt  out  1  request accepted this cycle
- disp_valid  out  1  one-cycle pulse; disp_data valid
- disp_data  out  8  read byte
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  13  byte offset into video RAM
- cpu_wdata  in  8  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data; valid with cpu_ready on reads
- mem_addr  out  13  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data; registered RAM, valid the cycle after the address
- frame_tick  in  1  one pulse per frame (vblank start)
- colour_enable  in  1  1 = animate colour_offset
- colour_offset  out  10  to adapter colour_offset

Behaviour:
- Reset (synchronous): all outputs 0, streak counter 0, frame divider 0, colour_offset 0, pipeline stages invalid. Any in-flight access is discarded: no disp_valid or cpu_ready follows a reset.
- One memory slot per cycle. Arbitration is evaluated combinationally in cycle N:
  - If disp_req and (not cpu_req or streak < STARVE_LIMIT): grant display.
  - Else if cpu_req: grant CPU.
  - Else: idle (mem_we = 0, mem_addr holds its previous value).
- Streak counter:
  - Increments on a display grant while cpu_req is high.
  - Clears on a CPU grant, or on any cycle where cpu_req is low.
  - Saturates at STARVE_LIMIT.
- Display address: mem_addr = disp_x*32 + disp_ybyte, computed in 13 bits. disp_gnt is high in cycle N, combinational.
- Display out of range: disp_x >= 224 is still granted, but no RAM access is made (mem_we = 0). The forced data is 0x00.
- Display latency:
  - Stage 1 register at the end of cycle N; data captured from mem_rdata at the end of cycle N+1.
  - disp_valid = 1 and disp_data are presented in cycle N+2. Latency is fixed at 2 cycles, and grants can issue back-to-back.
- CPU granted in cycle N:
  - mem_addr = cpu_addr.
  - mem_we = cpu_we only when cpu_addr < 7168.
  - mem_wdata = cpu_wdata.
- CPU completion:
  - Writes: cpu_ready in cycle N+1.
  - Reads: cpu_ready and cpu_rdata in cycle N+2.
  - Out-of-range writes are dropped but still acknowledged. Out-of-range reads return 0x00.
- The CPU cannot be re-granted while its own access is outstanding; it needs cpu_req held high after cpu_ready to be granted again. A read therefore blocks new CPU grants for cycles N+1 and N+2. Display grants continue during those cycles.
- Simultaneous disp_req and cpu_req with streak < STARVE_LIMIT: the display wins.
- Colour animator:
  - On frame_tick with colour_enable = 1, the divider increments.
  - When the divider reaches FRAME_DIV-1, it clears and colour_offset = (colour_offset + OFFSET_STEP) mod OFFSET_WRAP. Use 11-bit addition before the compare.
  - colour_enable = 0: divider and offset are held (frozen, not cleared).
  - frame_tick is ignored in the reset cycle.

Test Plan:
- Reset with disp_req=1 and cpu_req=1 held: all outputs 0 during reset. First grant goes to display the cycle after reset deasserts. disp_valid first rises 2 cycles later.
- Display-only stream disp_x=3, ybyte=0..31 on consecutive cycles, RAM preloaded with byte=addr[7:0]:
  - mem_addr runs 96..127.
  - disp_data runs 0x60..0x7F.
  - 32 disp_valid pulses, 2-cycle latency each.
- Continuous disp_req plus a CPU write cpu_addr=0x0100, data=0xA5: display granted 4 cycles, CPU granted on the 5th. mem_we=1 with addr 0x0100; cpu_ready 1 cycle later. Display resumes the next cycle.
- CPU read cpu_addr=7168: cpu_ready 2 cycles after grant, cpu_rdata=0x00, mem_we never asserted. CPU write to 7200 is acknowledged with mem_we=0.
- disp_x=224: disp_gnt=1, mem_we=0, disp_valid 2 cycles later with disp_data=0x00.
- Colour animator, FRAME_DIV=2, OFFSET_STEP=1: 392 frame_ticks bring colour_offset 0->195->0. Ticks while colour_enable=0 leave the offset unchanged. With OFFSET_STEP=5 starting at 195: next value is 4.

Source files
------------

// File: rtl/midway8080_vram_arbiter.sv
// Single-port video RAM arbiter for the Midway 8080 board: scanout and CPU share
// one RAM slot per cycle; also animates the colour band offset once per N frames.
module midway8080_vram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int FRAME_DIV    = 2,
  parameter int OFFSET_STEP  = 1,
  parameter int OFFSET_WRAP  = 196
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [7:0]  disp_x,
  input  logic [4:0]  disp_ybyte,
  output logic        disp_gnt,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        frame_tick,
  input  logic        colour_enable,
  output logic [9:0]  colour_offset
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);
  localparam logic [12:0]   VRAM_BYTES = 13'd7168;
  localparam logic [7:0]    DISP_COLS  = 8'd224;

  logic [SW-1:0] streak;
  logic          cpu_busy;
  logic          cpu_elig;
  logic          gnt_disp;
  logic          gnt_cpu;
  logic          disp_oor;
  logic          cpu_oor;
  logic [12:0]   disp_addr;
  logic [12:0]   addr_q;
  logic [7:0]    wdata_q;

  // Pipeline stages: *1 = address issued last cycle, *2 = data captured.
  logic          d1_valid, d1_oor;
  logic          d2_valid;
  logic [7:0]    d2_data;
  logic          c1_valid, c1_we, c1_oor;
  logic          c2_valid;
  logic [7:0]    c2_data;

  logic [DW-1:0] frame_div_q;
  logic [9:0]    offset_q;
  logic [10:0]   offset_sum;
  logic [10:0]   offset_next;

  // x*32 + ybyte is exactly the concatenation for 5-bit ybyte.
  assign disp_addr = {disp_x, disp_ybyte};
  assign disp_oor  = (disp_x >= DISP_COLS);
  assign cpu_oor   = (cpu_addr >= VRAM_BYTES);

  // The CPU stays ineligible until its own access has been acknowledged.
  assign cpu_busy  = c1_valid | c2_valid;
  assign cpu_elig  = cpu_req & ~cpu_busy;

  always_comb begin
    gnt_disp = 1'b0;
    gnt_cpu  = 1'b0;
    if (!reset) begin
      if (disp_req && (!cpu_elig || (streak < STREAK_MAX))) begin
        gnt_disp = 1'b1;
      end else if (cpu_elig) begin
        gnt_cpu = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we & ~cpu_oor;
      mem_wdata = cpu_wdata;
    end else if (gnt_disp && !disp_oor) begin
      mem_addr = disp_addr;
    end
  end

  assign disp_gnt   = gnt_disp;
  assign disp_valid = d2_valid;
  assign disp_data  = d2_data;
  assign cpu_ready  = (c1_valid & c1_we) | c2_valid;
  assign cpu_rdata  = c2_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      streak   <= '0;
      d1_valid <= 1'b0;
      d1_oor   <= 1'b0;
      d2_valid <= 1'b0;
      d2_data  <= '0;
      c1_valid <= 1'b0;
      c1_we    <= 1'b0;
      c1_oor   <= 1'b0;
      c2_valid <= 1'b0;
      c2_data  <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;

      if (!cpu_req || gnt_cpu) begin
        streak <= '0;
      end else if (gnt_disp && (streak < STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end

      d1_valid <= gnt_disp;
      d1_oor   <= disp_oor;
      d2_valid <= d1_valid;
      if (d1_valid) begin
        d2_data <= d1_oor ? 8'h00 : mem_rdata;
      end

      c1_valid <= gnt_cpu;
      c1_we    <= cpu_we;
      c1_oor   <= cpu_oor;
      c2_valid <= c1_valid & ~c1_we;
      if (c1_valid && !c1_we) begin
        c2_data <= c1_oor ? 8'h00 : mem_rdata;
      end
    end
  end

  // Widen before the wrap compare so large steps cannot overflow 10 bits.
  assign offset_sum  = {1'b0, offset_q} + 11'(OFFSET_STEP);
  assign offset_next = (offset_sum >= 11'(OFFSET_WRAP)) ? (offset_sum - 11'(OFFSET_WRAP))
                                                        : offset_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_div_q <= '0;
      offset_q    <= '0;
    end else if (frame_tick && colour_enable) begin
      if (frame_div_q == DIV_LAST) begin
        frame_div_q <= '0;
        offset_q    <= offset_next[9:0];
      end else begin
        frame_div_q <= frame_div_q + 1'b1;
      end
    end
  end

  assign colour_offset = offset_q;

endmodule

// File: tb/tb_midway8080_vram_arbiter.sv
// Directed bench for the video RAM arbiter: reset, scanout stream, CPU starvation
// limit, out-of-range accesses and the colour offset animator.
module tb_midway8080_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        disp_req;
  logic [7:0]  disp_x;
  logic [4:0]  disp_ybyte;
  logic        disp_gnt;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        frame_tick;
  logic        colour_enable;
  logic [9:0]  colour_offset;

  logic        disp_gnt_b, disp_valid_b, cpu_ready_b, mem_we_b;
  logic [7:0]  disp_data_b, cpu_rdata_b, mem_wdata_b;
  logic [12:0] mem_addr_b;
  logic [9:0]  colour_offset_b;

  logic [7:0]  ram [0:8191];
  int          total;
  int          bad;

  midway8080_vram_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_ybyte(disp_ybyte),
    .disp_gnt(disp_gnt), .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .frame_tick(frame_tick), .colour_enable(colour_enable), .colour_offset(colour_offset)
  );

  midway8080_vram_arbiter #(.OFFSET_STEP(5)) dut_step5 (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_ybyte(disp_ybyte),
    .disp_gnt(disp_gnt_b), .disp_valid(disp_valid_b), .disp_data(disp_data_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready_b), .cpu_rdata(cpu_rdata_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
    .frame_tick(frame_tick), .colour_enable(colour_enable), .colour_offset(colour_offset_b)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port RAM model, preloaded with byte = addr[7:0]
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = i[7:0];
    ram[7168] = 8'h5A;
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    next_cycle();
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    disp_req = 1'b1;
    disp_x = 8'd1;
    disp_ybyte = 5'd2;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    frame_tick = 1'b1;
    colour_enable = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_disp_gnt", disp_gnt, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_colour", colour_offset, 0);

    // First cycle out of reset: display wins over the CPU
    next_cycle();
    reset = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    check("first_gnt", disp_gnt, 1);
    check("first_addr", mem_addr, 34);
    next_cycle();
    disp_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("first_valid_early", disp_valid, 0);
    next_cycle();
    @(negedge clk);
    check("first_valid", disp_valid, 1);
    check("first_data", disp_data, 8'h22);
    check("colour_after_rst", colour_offset, 0);

    // Scanout stream, column 3
    for (int i = 0; i < 34; i++) begin
      next_cycle();
      if (i < 32) begin
        disp_req = 1'b1;
        disp_x = 8'd3;
        disp_ybyte = 5'(i);
      end else begin
        disp_req = 1'b0;
      end
      @(negedge clk);
      if (i < 32) begin
        check("stream_gnt", disp_gnt, 1);
        check("stream_addr", mem_addr, 32'(96 + i));
      end
      if (i >= 2) begin
        check("stream_valid", disp_valid, 1);
        check("stream_data", disp_data, 32'(8'h60 + i - 2));
      end else begin
        check("stream_valid_lat", disp_valid, 0);
      end
    end
    next_cycle();
    @(negedge clk);
    check("stream_drained", disp_valid, 0);

    // Starvation limit: four display grants, then the CPU write
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      if (i == 0) begin
        disp_req = 1'b1;
        disp_x = 8'd0;
        disp_ybyte = 5'd0;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 13'h0100;
        cpu_wdata = 8'hA5;
      end
      if (i == 6) cpu_req = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        check("starve_disp_gnt", disp_gnt, 1);
        check("starve_no_we", mem_we, 0);
        check("starve_no_ready", cpu_ready, 0);
      end else if (i == 4) begin
        check("starve_cpu_slot", disp_gnt, 0);
        check("starve_we", mem_we, 1);
        check("starve_addr", mem_addr, 13'h0100);
        check("starve_wdata", mem_wdata, 8'hA5);
        check("starve_ready_early", cpu_ready, 0);
      end else if (i == 5) begin
        check("starve_ready", cpu_ready, 1);
        check("starve_resume", disp_gnt, 1);
      end else begin
        check("starve_ready_once", cpu_ready, 0);
      end
    end
    disp_req = 1'b0;
    repeat (3) next_cycle();
    check("ram_written", ram[256], 8'hA5);

    // In-range read held across its own completion: must not re-grant
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i == 0) begin
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 13'h0100;
      end
      if (i == 3) cpu_req = 1'b0;
      @(negedge clk);
      if (i == 0) check("rd_addr", mem_addr, 13'h0100);
      if (i == 2) begin
        check("rd_ready", cpu_ready, 1);
        check("rd_data", cpu_rdata, 8'hA5);
      end else begin
        check("rd_ready_idle", cpu_ready, 0);
      end
    end

    // Out-of-range read
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) begin
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 13'd7168;
      end
      if (i == 3) cpu_req = 1'b0;
      @(negedge clk);
      check("oor_rd_no_we", mem_we, 0);
      if (i == 0) check("oor_rd_addr", mem_addr, 13'd7168);
      if (i == 2) begin
        check("oor_rd_ready", cpu_ready, 1);
        check("oor_rd_data", cpu_rdata, 8'h00);
      end else begin
        check("oor_rd_ready_idle", cpu_ready, 0);
      end
    end

    // Out-of-range write: acknowledged, dropped
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 0) begin
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 13'd7200;
        cpu_wdata = 8'h33;
      end
      if (i == 2) cpu_req = 1'b0;
      @(negedge clk);
      if (i == 0) begin
        check("oor_wr_no_we", mem_we, 0);
        check("oor_wr_addr", mem_addr, 13'd7200);
      end
      if (i == 1) check("oor_wr_ready", cpu_ready, 1);
      if (i == 2) check("oor_wr_ready_once", cpu_ready, 0);
    end
    check("oor_wr_ram_intact", ram[7200], 8'h20);

    // Out-of-range display column
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) begin
        disp_req = 1'b1;
        disp_x = 8'd224;
        disp_ybyte = 5'd5;
      end
      if (i == 1) disp_req = 1'b0;
      @(negedge clk);
      if (i == 0) begin
        check("oor_disp_gnt", disp_gnt, 1);
        check("oor_disp_no_we", mem_we, 0);
      end
      if (i == 2) begin
        check("oor_disp_valid", disp_valid, 1);
        check("oor_disp_data", disp_data, 8'h00);
      end else begin
        check("oor_disp_valid_idle", disp_valid, 0);
      end
    end

    // Colour animator: step 1 and step 5 instances share frame_tick
    repeat (78) pulse_frame();
    @(negedge clk);
    check("colour_78", colour_offset, 39);
    check("colour5_78", colour_offset_b, 195);
    repeat (2) pulse_frame();
    @(negedge clk);
    check("colour_80", colour_offset, 40);
    check("colour5_wrap", colour_offset_b, 4);
    repeat (310) pulse_frame();
    @(negedge clk);
    check("colour_390", colour_offset, 195);
    repeat (2) pulse_frame();
    @(negedge clk);
    check("colour_392", colour_offset, 0);

    // Freeze mid-divide: divider must be held, not cleared
    pulse_frame();
    colour_enable = 1'b0;
    repeat (3) pulse_frame();
    @(negedge clk);
    check("colour_frozen", colour_offset, 0);
    colour_enable = 1'b1;
    pulse_frame();
    @(negedge clk);
    check("colour_resume", colour_offset, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
